// File: rtl/fan_speed_ctrl.sv
// Fan/motor speed-mode controller: button synchronizer and debouncer, three-level
// mode FSM, soft-ramped PWM duty and an emergency STOP.
module fan_speed_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned RAMP_PERIODS    = 2,
    parameter int unsigned DUTY_MID        = 8,
    parameter int unsigned DUTY_MAX        = 15
) (
    input  logic       CLK,
    input  logic       CLEAR,
    input  logic       BTN,
    input  logic       STOP,
    output logic [1:0] SPEED,
    output logic [3:0] DUTY,
    output logic       PWM,
    output logic       BUSY,
    output logic       PRESS
);

    localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] RP_LAST  = 8'(RAMP_PERIODS - 1);
    localparam logic [3:0] TGT_MID  = 4'(DUTY_MID);
    localparam logic [3:0] TGT_MAX  = 4'(DUTY_MAX);

    typedef enum logic [1:0] {
        OFF  = 2'b00,
        LOW  = 2'b01,
        HIGH = 2'b11
    } mode_t;

    mode_t      mode;
    logic       s1;
    logic       btn_s;
    logic       db;
    logic       db_prev;
    logic [7:0] db_cnt;
    logic [3:0] cnt;
    logic [7:0] pc;
    logic [3:0] target;

    always_comb begin
        target = '0;
        case (mode)
            LOW:     target = TGT_MID;
            HIGH:    target = TGT_MAX;
            default: target = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            s1      <= 1'b0;
            btn_s   <= 1'b0;
            db      <= 1'b0;
            db_prev <= 1'b0;
            db_cnt  <= '0;
            PRESS   <= 1'b0;
            cnt     <= '0;
            pc      <= '0;
            DUTY    <= '0;
            mode    <= OFF;
        end else begin
            s1    <= BTN;
            btn_s <= s1;

            // A single matching sample restarts the mismatch streak.
            if (btn_s == db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db     <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 8'd1;
            end

            db_prev <= db;
            PRESS   <= db & ~db_prev;

            cnt <= cnt + 4'd1;
            if (cnt == 4'hF) begin
                pc <= (pc == RP_LAST) ? '0 : pc + 8'd1;
            end

            if (STOP) begin
                mode <= OFF;
                DUTY <= '0;
            end else begin
                case (mode)
                    OFF:     if (PRESS) mode <= LOW;
                    LOW:     if (PRESS) mode <= HIGH;
                    HIGH:    if (PRESS) mode <= OFF;
                    default: mode <= OFF;
                endcase

                if (cnt == 4'hF && pc == RP_LAST) begin
                    if (DUTY < target) begin
                        DUTY <= DUTY + 4'd1;
                    end else if (DUTY > target) begin
                        DUTY <= DUTY - 4'd1;
                    end
                end
            end
        end
    end

    assign SPEED = mode;
    assign PWM   = (cnt < DUTY);
    assign BUSY  = (DUTY != target);

endmodule
